// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - shared types and March C- element tables for the MBIST controller
package mbist_pkg;

    typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_e;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    // One bit per element, bit index = element number.
    localparam logic [5:0] ELEM_DOWN    = 6'b111000;
    localparam logic [5:0] ELEM_TWO_OPS = 6'b011110;
    localparam logic [5:0] SLOT0_READ   = 6'b111110;
    localparam logic [5:0] SLOT0_POL    = 6'b010100;
    localparam logic [5:0] SLOT1_POL    = 6'b001010;

    function automatic logic elem_down(input march_elem_e e);
        return ELEM_DOWN[e];
    endfunction

    function automatic logic elem_last_slot(input march_elem_e e, input logic slot);
        return slot | ~ELEM_TWO_OPS[e];
    endfunction

    // The second slot of a two-op element is always a write.
    function automatic logic op_is_read(input march_elem_e e, input logic slot);
        return slot ? 1'b0 : SLOT0_READ[e];
    endfunction

    function automatic logic op_pol(input march_elem_e e, input logic slot);
        return slot ? SLOT1_POL[e] : SLOT0_POL[e];
    endfunction

endpackage

// File: rtl/mbist_cmp_pipe.sv
// rtl/mbist_cmp_pipe.sv - read-latency matched expected/tag pipeline, comparator and first-failure capture
module mbist_cmp_pipe
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              issue,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [ADDR_W-1:0] tag_addr,
    input  logic [2:0]        tag_elem,
    input  logic [2:0]        tag_bg,
    input  logic [DATA_W-1:0] rdata,
    output logic              fail,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [2:0]        fail_bg
);

    logic              vld    [RD_LAT];
    logic [DATA_W-1:0] exp_q  [RD_LAT];
    logic [ADDR_W-1:0] addr_q [RD_LAT];
    logic [2:0]        elem_q [RD_LAT];
    logic [2:0]        bg_q   [RD_LAT];
    logic              miss;

    assign miss = vld[RD_LAT-1] && (rdata != exp_q[RD_LAT-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld[i]    <= 1'b0;
                exp_q[i]  <= '0;
                addr_q[i] <= '0;
                elem_q[i] <= '0;
                bg_q[i]   <= '0;
            end
        end else begin
            vld[0]    <= issue;
            exp_q[0]  <= exp_data;
            addr_q[0] <= tag_addr;
            elem_q[0] <= tag_elem;
            bg_q[0]   <= tag_bg;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i]    <= vld[i-1];
                exp_q[i]  <= exp_q[i-1];
                addr_q[i] <= addr_q[i-1];
                elem_q[i] <= elem_q[i-1];
                bg_q[i]   <= bg_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            fail      <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_bg   <= '0;
        end else if (miss) begin
            fail <= 1'b1;
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
            if (!fail) begin
                fail_addr <= addr_q[RD_LAT-1];
                fail_elem <= elem_q[RD_LAT-1];
                fail_bg   <= bg_q[RD_LAT-1];
            end
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- sequencer: FSM, address/op/element/background counters
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int NUM_BG = 8,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [2:0]        fail_bg,
    output logic [2:0]        q,
    input  logic [DATA_W-1:0] data_t,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
    localparam logic [2:0]        BG_LAST    = 3'(NUM_BG - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

    state_e            state, state_nxt;
    march_elem_e       elem, elem_inc;
    logic              slot;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        bg;
    logic [1:0]        drain_cnt;
    logic              last_slot, at_end, final_op, launch, op_rd;
    logic [DATA_W-1:0] op_data;

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        elem_inc  = march_elem_e'(elem + 3'd1);
        last_slot = elem_last_slot(elem, slot);
        at_end    = elem_down(elem) ? (addr == '0) : (addr == ADDR_LAST);
        final_op  = last_slot && at_end && (elem == M5) && (bg == BG_LAST);
        op_rd     = op_is_read(elem, slot);
        op_data   = op_pol(elem, slot) ? ~data_t : data_t;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    launch    = 1'b1;
                end
            end
            RUN:     if (final_op) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase

        busy      = (state == RUN) || (state == DRAIN);
        done      = (state == DONE);
        mem_re    = (state == RUN) && op_rd;
        mem_we    = (state == RUN) && !op_rd;
        mem_wdata = mem_we ? op_data : '0;
        mem_addr  = addr;
        q         = bg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            elem      <= M0;
            slot      <= 1'b0;
            addr      <= '0;
            bg        <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (launch) begin
                elem <= M0;
                slot <= 1'b0;
                addr <= '0;
                bg   <= '0;
            end else if (state == RUN) begin
                if (!last_slot) begin
                    slot <= 1'b1;
                end else begin
                    slot <= 1'b0;
                    if (!at_end) begin
                        addr <= elem_down(elem) ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
                    end else if (elem == M5) begin
                        // Wraps back to M0/addr 0/q 0 after the last background.
                        elem <= M0;
                        addr <= '0;
                        bg   <= (bg == BG_LAST) ? 3'd0 : bg + 3'd1;
                    end else begin
                        elem <= elem_inc;
                        addr <= elem_down(elem_inc) ? ADDR_LAST : '0;
                    end
                end
            end
        end
    end

    mbist_cmp_pipe #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT),
        .ERR_W  (ERR_W)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .clear     (launch),
        .issue     (mem_re),
        .exp_data  (op_data),
        .tag_addr  (addr),
        .tag_elem  (elem),
        .tag_bg    (bg),
        .rdata     (mem_rdata),
        .fail      (fail),
        .err_cnt   (err_cnt),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .fail_bg   (fail_bg)
    );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb/tb_mbist_march_ctrl.sv - directed bench for mbist_march_ctrl (defaults, RD_LAT=3, ERR_W=2)
module tb_mbist_march_ctrl;

    typedef struct {
        int done_rel;
        int fail;
        int err;
        int faddr;
        int felem;
        int fbg;
    } exp_t;

    typedef struct {
        int rel;
        int q;
    } qexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errors = 0;
    int   checks = 0;
    int   t0 = 0;
    int   wraps = 0;
    // 0: fault-free, stub A5^q; 1: bit0 of addr 5 stuck-at-1, stub 00; 2: all bits stuck-at-1, stub 00
    int   fmode [3] = '{0, 0, 2};
    exp_t  sb  [$];
    qexp_t qsb [$];

    logic [2:0]      rst_v = 3'b111;
    logic [2:0]      start_v = 3'b000;
    logic [2:0]      done_v, busy_v, fail_v, we_v, re_v;
    logic [2:0][7:0] err_v, wdata_v;
    logic [2:0][3:0] faddr_v, addr_v;
    logic [2:0][2:0] felem_v, fbg_v, q_v;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int RL = (g == 1) ? 3 : 1;
        localparam int EW = (g == 2) ? 2 : 8;

        logic [2:0]    q, felem, fbg;
        logic [7:0]    data_t, wdata, rdata, rd_raw;
        logic [3:0]    addr, faddr;
        logic          we, re, busy, done, fail;
        logic [EW-1:0] err;
        logic [7:0]    mem [16];
        logic [7:0]    rq  [RL];

        assign data_t = (fmode[g] == 0) ? (8'hA5 ^ {5'b0, q}) : 8'h00;
        assign rd_raw = (fmode[g] == 2) ? 8'hFF :
                        (fmode[g] == 1 && addr == 4'd5) ? (mem[addr] | 8'h01) : mem[addr];
        assign rdata  = rq[RL-1];

        always @(posedge clk) begin
            if (we) mem[addr] <= wdata;
            rq[0] <= re ? rd_raw : 8'h00;
            for (int i = 1; i < RL; i++) rq[i] <= rq[i-1];
        end

        mbist_march_ctrl #(
            .ADDR_W(4), .DATA_W(8), .NUM_BG(8), .RD_LAT(RL), .ERR_W(EW)
        ) dut (
            .clk       (clk),
            .rst       (rst_v[g]),
            .start     (start_v[g]),
            .busy      (busy),
            .done      (done),
            .fail      (fail),
            .err_cnt   (err),
            .fail_addr (faddr),
            .fail_elem (felem),
            .fail_bg   (fbg),
            .q         (q),
            .data_t    (data_t),
            .mem_addr  (addr),
            .mem_we    (we),
            .mem_re    (re),
            .mem_wdata (wdata),
            .mem_rdata (rdata)
        );

        assign done_v[g]  = done;
        assign busy_v[g]  = busy;
        assign fail_v[g]  = fail;
        assign we_v[g]    = we;
        assign re_v[g]    = re;
        assign err_v[g]   = 8'(err);
        assign wdata_v[g] = wdata;
        assign faddr_v[g] = faddr;
        assign addr_v[g]  = addr;
        assign felem_v[g] = felem;
        assign fbg_v[g]   = fbg;
        assign q_v[g]     = q;
    end

    logic [7:0] err2_prev = 8'd0;
    always @(negedge clk) begin
        if (err2_prev == 8'd3 && err_v[2] != 8'd3) wraps++;
        err2_prev = err_v[2];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_done(input int rel, input int f, input int e, input int a, input int el, input int b);
        exp_t x;
        x.done_rel = rel; x.fail = f; x.err = e; x.faddr = a; x.felem = el; x.fbg = b;
        sb.push_back(x);
    endtask

    task automatic push_q_steps();
        qexp_t x;
        x.rel = 1; x.q = 0;
        qsb.push_back(x);
        for (int k = 1; k < 8; k++) begin
            x.rel = 160 * k;     x.q = k - 1; qsb.push_back(x);
            x.rel = 160 * k + 1; x.q = k;     qsb.push_back(x);
        end
    endtask

    // Leaves the caller at the negedge of cycle T+1.
    task automatic start_pulse(input int g);
        @(negedge clk);
        start_v[g] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_v[g] = 1'b0;
    endtask

    task automatic run_to_done(input int g, input int mid_rel);
        int    rel, ops, last, viol, found;
        exp_t  e;
        qexp_t qe;
        ops = 0; last = -1; viol = 0; found = 0;
        for (int i = 0; i < 3000 && found == 0; i++) begin
            rel = cyc - t0;
            start_v[g] = (rel == mid_rel);
            if (we_v[g] || re_v[g]) begin ops++; last = rel; end
            if (rel >= 1 && rel <= 1280 && !(we_v[g] ^ re_v[g])) viol++;
            if (!we_v[g] && wdata_v[g] != 8'd0) viol++;
            if (qsb.size() > 0 && qsb[0].rel == rel) begin
                qe = qsb.pop_front();
                chk("q_step", 32'(q_v[g]), qe.q);
            end
            if (done_v[g]) found = 1;
            else @(negedge clk);
        end
        start_v[g] = 1'b0;
        chk("done_seen", found, 1);
        chk("q_steps_left", qsb.size(), 0);
        chk("op_count", ops, 1280);
        chk("last_op_rel", last, 1280);
        chk("op_protocol", viol, 0);
        chk("busy_at_done", 32'(busy_v[g]), 0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("done_rel", cyc - t0, e.done_rel);
            chk("fail", 32'(fail_v[g]), e.fail);
            chk("err_cnt", 32'(err_v[g]), e.err);
            chk("fail_addr", 32'(faddr_v[g]), e.faddr);
            chk("fail_elem", 32'(felem_v[g]), e.felem);
            chk("fail_bg", 32'(fbg_v[g]), e.fbg);
        end
    endtask

    initial begin
        int ops;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_v[0]), 0);
        chk("rst_done", 32'(done_v), 0);
        chk("rst_fail", 32'(fail_v[0]), 0);
        chk("rst_err", 32'(err_v[0]), 0);
        chk("rst_q", 32'(q_v[0]), 0);
        chk("rst_memop", 32'({we_v, re_v}), 0);
        rst_v = 3'b000;
        @(negedge clk);
        chk("idle_done", 32'(done_v), 0);

        // Fault-free run with a start pulse injected mid-RUN
        push_q_steps();
        expect_done(1282, 0, 0, 0, 0, 0);
        start_pulse(0);
        run_to_done(0, 50);
        repeat (3) @(negedge clk);
        chk("done_held", 32'(done_v[0]), 1);

        // Stuck-at fault, started from DONE
        fmode[0] = 1;
        expect_done(1282, 1, 24, 5, 1, 0);
        start_pulse(0);
        run_to_done(0, -1);

        // Restart from DONE clears status; reset at T+400 aborts
        start_pulse(0);
        chk("restart_done", 32'(done_v[0]), 0);
        chk("restart_fail", 32'(fail_v[0]), 0);
        chk("restart_err", 32'(err_v[0]), 0);
        chk("restart_faddr", 32'(faddr_v[0]), 0);
        chk("restart_felem", 32'(felem_v[0]), 0);
        chk("restart_busy", 32'(busy_v[0]), 1);
        chk("restart_first_we", 32'(we_v[0]), 1);
        for (int i = 0; i < 500 && (cyc - t0) < 400; i++) @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        chk("abort_status", 32'({busy_v[0], done_v[0], fail_v[0], q_v[0]}), 0);
        chk("abort_err", 32'(err_v[0]), 0);
        chk("abort_mem", 32'({we_v[0], re_v[0], wdata_v[0], addr_v[0]}), 0);
        ops = 0;
        repeat (5) begin
            @(negedge clk);
            if (we_v[0] || re_v[0]) ops++;
        end
        chk("abort_no_ops", ops, 0);
        expect_done(1282, 1, 24, 5, 1, 0);
        start_pulse(0);
        run_to_done(0, -1);

        // RD_LAT=3 fault-free
        expect_done(1284, 0, 0, 0, 0, 0);
        start_pulse(1);
        run_to_done(1, -1);

        // ERR_W=2, all bits stuck
        expect_done(1282, 1, 3, 0, 1, 0);
        start_pulse(2);
        run_to_done(2, -1);
        chk("err_no_wrap", wraps, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
